// File: rtl/core_pkg.sv
// Shared core definitions: integer register file geometry, types and ABI names.
package core_pkg;

   localparam int XLEN   = 64;
   localparam int NREG   = 32;
   localparam int REG_AW = $clog2(NREG);

   typedef logic [REG_AW-1:0] reg_addr_t;
   typedef logic [XLEN-1:0]   xword_t;

   // RISC-V ABI register names
   localparam reg_addr_t ZERO = reg_addr_t'(0);
   localparam reg_addr_t RA   = reg_addr_t'(1);
   localparam reg_addr_t SP   = reg_addr_t'(2);
   localparam reg_addr_t GP   = reg_addr_t'(3);
   localparam reg_addr_t TP   = reg_addr_t'(4);
   localparam reg_addr_t T0   = reg_addr_t'(5);
   localparam reg_addr_t T1   = reg_addr_t'(6);
   localparam reg_addr_t T2   = reg_addr_t'(7);
   localparam reg_addr_t S0   = reg_addr_t'(8);
   localparam reg_addr_t S1   = reg_addr_t'(9);
   localparam reg_addr_t A0   = reg_addr_t'(10);
   localparam reg_addr_t A1   = reg_addr_t'(11);
   localparam reg_addr_t T6   = reg_addr_t'(31);

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: x0 forced to zero, optional write-first bypass.
module regfile_read_port #(
   parameter int XLEN   = 64,
   parameter int NREG   = 32,
   parameter int AW     = $clog2(NREG),
   parameter int BYPASS = 1
) (
   input  logic [AW-1:0]   addr_i,
   input  logic [XLEN-1:0] regs_i [1:NREG-1],
   input  logic [AW-1:0]   wr_addr_i,
   input  logic [XLEN-1:0] wr_data_i,
   input  logic            wr_en_i,
   output logic [XLEN-1:0] data_o
);
   import core_pkg::*;

   logic [XLEN-1:0] stored;
   logic            bypass_hit;

   // Select the stored word; address 0 has no storage and falls through as zero.
   always_comb begin
      stored = '0;
      for (int i = 1; i < NREG; i++) begin
         if (addr_i == AW'(i)) stored = regs_i[i];
      end
   end

   // Forward an in-flight write when enabled, then force x0 to zero last.
   always_comb begin
      bypass_hit = (BYPASS != 0) && wr_en_i && (wr_addr_i != '0) && (wr_addr_i == addr_i);
      data_o     = bypass_hit ? wr_data_i : stored;
      if (addr_i == '0) data_o = '0;
   end

endmodule

// File: rtl/register_file.sv
// RV64 integer register file: x1..x(NREG-1) storage, two read ports, one write port.
module register_file #(
   parameter int XLEN   = core_pkg::XLEN,
   parameter int NREG   = core_pkg::NREG,
   parameter int BYPASS = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [$clog2(NREG)-1:0] rs1,
   input  logic [$clog2(NREG)-1:0] rs2,
   output logic [XLEN-1:0]         out1,
   output logic [XLEN-1:0]         out2,
   input  logic [$clog2(NREG)-1:0] rd,
   input  logic [XLEN-1:0]         rd_in,
   input  logic                    rd_we
);
   import core_pkg::*;

   localparam int AW = $clog2(NREG);

   if ((NREG < 2) || ((NREG & (NREG - 1)) != 0)) begin : g_nreg_check
      $error("register_file: NREG must be a power of two");
   end

   logic [XLEN-1:0] mem_q [1:NREG-1];
   logic [XLEN-1:0] mem_d [1:NREG-1];

   // Next-state of the array: only the addressed register takes the write data.
   always_comb begin
      mem_d = mem_q;
      for (int i = 1; i < NREG; i++) begin
         if (rd_we && (rd == AW'(i))) mem_d[i] = rd_in;
      end
   end

   // Storage update; reset wins over a write in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 1; i < NREG; i++) mem_q[i] <= '0;
      end else begin
         for (int i = 1; i < NREG; i++) mem_q[i] <= mem_d[i];
      end
   end

   regfile_read_port #(
      .XLEN   (XLEN),
      .NREG   (NREG),
      .AW     (AW),
      .BYPASS (BYPASS)
   ) u_port1 (
      .addr_i    (rs1),
      .regs_i    (mem_q),
      .wr_addr_i (rd),
      .wr_data_i (rd_in),
      .wr_en_i   (rd_we),
      .data_o    (out1)
   );

   regfile_read_port #(
      .XLEN   (XLEN),
      .NREG   (NREG),
      .AW     (AW),
      .BYPASS (BYPASS)
   ) u_port2 (
      .addr_i    (rs2),
      .regs_i    (mem_q),
      .wr_addr_i (rd),
      .wr_data_i (rd_in),
      .wr_en_i   (rd_we),
      .data_o    (out2)
   );

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: a write-first instance and a no-bypass instance share inputs.
module tb_register_file;

   logic        clk;
   logic        rst;
   logic [4:0]  rs1, rs2, rd;
   logic [63:0] rd_in;
   logic        rd_we;
   logic [63:0] out1, out2;      // BYPASS=1
   logic [63:0] nb_out1, nb_out2; // BYPASS=0

   int checks = 0;
   int errors = 0;

   // Reference: plain array of architectural register values.
   logic [63:0] model [32];

   register_file #(.XLEN(64), .NREG(32), .BYPASS(1)) dut (
      .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .out1(out1), .out2(out2),
      .rd(rd), .rd_in(rd_in), .rd_we(rd_we)
   );

   register_file #(.XLEN(64), .NREG(32), .BYPASS(0)) dut_nb (
      .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .out1(nb_out1), .out2(nb_out2),
      .rd(rd), .rd_in(rd_in), .rd_we(rd_we)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected read value for the current inputs.
   function automatic logic [63:0] exp_read(input logic [4:0] a, input bit byp);
      if (a == 5'd0) return 64'd0;
      if (byp && rd_we && rd != 5'd0 && rd == a) return rd_in;
      return model[a];
   endfunction

   // Advance one rising edge, updating the model from the inputs held across it.
   task automatic clock_edge();
      if (rst) begin
         for (int i = 0; i < 32; i++) model[i] = 64'd0;
      end else if (rd_we && rd != 5'd0) begin
         model[rd] = rd_in;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; rd_we = 1'b0; rd = 5'd0; rd_in = 64'd0; rs1 = 5'd0; rs2 = 5'd0;
      #1;
      checks++;
      if (out1 !== 64'd0 || nb_out2 !== 64'd0) begin
         errors++; $display("FAIL pre_reset_x0: out1=%h nb_out2=%h expected 0", out1, nb_out2);
      end
      rst = 1'b1;
      repeat (5) clock_edge();
      rst = 1'b0;
      for (int i = 0; i < 32; i++) begin
         rs1 = 5'(i); rs2 = 5'(31 - i);
         #1;
         checks++;
         if (out1 !== 64'd0 || out2 !== 64'd0 || nb_out1 !== 64'd0 || nb_out2 !== 64'd0) begin
            errors++;
            $display("FAIL reset_sweep[%0d]: out1=%h out2=%h nb1=%h nb2=%h expected 0",
                     i, out1, out2, nb_out1, nb_out2);
         end
      end
   endtask

   task automatic test_basic_write();
      rd = 5'd1; rd_in = 64'd1; rd_we = 1'b1;
      clock_edge();
      rd_we = 1'b0; rs1 = 5'd1; rs2 = 5'd0;
      #1;
      checks++;
      if (out1 !== 64'd1 || out2 !== 64'd0) begin
         errors++; $display("FAIL basic_x1: out1=%h out2=%h expected 1 and 0", out1, out2);
      end
      rd = 5'd31; rd_in = 64'hDEAD_BEEF_0123_4567; rd_we = 1'b1;
      clock_edge();
      rd_we = 1'b0; rd_in = 64'd0; rs1 = 5'd31; rs2 = 5'd31;
      #1;
      checks++;
      if (out1 !== 64'hDEAD_BEEF_0123_4567 || nb_out2 !== 64'hDEAD_BEEF_0123_4567) begin
         errors++; $display("FAIL basic_x31: out1=%h nb_out2=%h expected deadbeef01234567", out1, nb_out2);
      end
   endtask

   task automatic test_x0();
      rd = 5'd0; rd_in = 64'hFFFF_FFFF_FFFF_FFFF; rd_we = 1'b1; rs1 = 5'd0; rs2 = 5'd0;
      #1;
      checks++;
      if (out1 !== 64'd0 || out2 !== 64'd0) begin
         errors++; $display("FAIL x0_write_cycle: out1=%h out2=%h expected 0", out1, out2);
      end
      clock_edge();
      rd_we = 1'b0;
      #1;
      checks++;
      if (out1 !== 64'd0 || out2 !== 64'd0 || nb_out1 !== 64'd0) begin
         errors++; $display("FAIL x0_after: out1=%h out2=%h nb1=%h expected 0", out1, out2, nb_out1);
      end
   endtask

   task automatic test_bypass();
      rd = 5'd5; rd_in = 64'h11; rd_we = 1'b1;
      clock_edge();
      rd_in = 64'hA5; rs1 = 5'd5; rs2 = 5'd5;
      #1;
      checks++;
      if (out1 !== 64'hA5 || out2 !== 64'hA5) begin
         errors++; $display("FAIL bypass_same_cycle: out1=%h out2=%h expected a5", out1, out2);
      end
      checks++;
      if (nb_out1 !== 64'h11) begin
         errors++; $display("FAIL nobypass_before: nb_out1=%h expected 11", nb_out1);
      end
      clock_edge();
      rd_we = 1'b0;
      #1;
      checks++;
      if (nb_out1 !== 64'hA5 || out1 !== 64'hA5) begin
         errors++; $display("FAIL nobypass_after: nb_out1=%h out1=%h expected a5", nb_out1, out1);
      end
   endtask

   task automatic test_we_gating();
      rd = 5'd3; rd_in = 64'h1234; rd_we = 1'b1;
      clock_edge();
      rd_in = 64'd7; rd_we = 1'b0; rs1 = 5'd3; rs2 = 5'd3;
      #1;
      checks++;
      if (out1 !== 64'h1234) begin
         errors++; $display("FAIL we_gate_same_cycle: out1=%h expected 1234", out1);
      end
      clock_edge();
      checks++;
      if (out1 !== 64'h1234 || nb_out2 !== 64'h1234) begin
         errors++; $display("FAIL we_gate_after: out1=%h nb_out2=%h expected 1234", out1, nb_out2);
      end
   endtask

   task automatic test_reset_priority();
      rd = 5'd2; rd_in = 64'h55; rd_we = 1'b1;
      clock_edge();
      rd_in = 64'h99; rst = 1'b1; rs1 = 5'd2; rs2 = 5'd2;
      #1;
      checks++;
      if (out1 !== 64'h99 || nb_out2 !== 64'h55) begin
         errors++; $display("FAIL reset_bypass: out1=%h nb_out2=%h expected 99 and 55", out1, nb_out2);
      end
      clock_edge();
      rst = 1'b0; rd_we = 1'b0;
      #1;
      checks++;
      if (out1 !== 64'd0 || nb_out1 !== 64'd0) begin
         errors++; $display("FAIL reset_prio_x2: out1=%h nb_out1=%h expected 0", out1, nb_out1);
      end
      rs1 = 5'd1; rs2 = 5'd31;
      #1;
      checks++;
      if (out1 !== 64'd0 || out2 !== 64'd0) begin
         errors++; $display("FAIL reset_prio_x1_x31: out1=%h out2=%h expected 0", out1, out2);
      end
   endtask

   task automatic test_random();
      logic [63:0] e1, e2, n1, n2;
      for (int k = 0; k < 400; k++) begin
         rst   = ($urandom_range(0, 39) == 0);
         rd_we = ($urandom_range(0, 3) != 0);
         rd    = 5'($urandom_range(0, 31));
         rd_in = {$urandom, $urandom};
         rs1   = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
         rs2   = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
         #1;
         e1 = exp_read(rs1, 1'b1); e2 = exp_read(rs2, 1'b1);
         n1 = exp_read(rs1, 1'b0); n2 = exp_read(rs2, 1'b0);
         checks++;
         if (out1 !== e1 || out2 !== e2) begin
            errors++;
            $display("FAIL rand_bypass[%0d]: rs1=%0d out1=%h exp %h rs2=%0d out2=%h exp %h",
                     k, rs1, out1, e1, rs2, out2, e2);
         end
         checks++;
         if (nb_out1 !== n1 || nb_out2 !== n2) begin
            errors++;
            $display("FAIL rand_nobypass[%0d]: rs1=%0d nb1=%h exp %h rs2=%0d nb2=%h exp %h",
                     k, rs1, nb_out1, n1, rs2, nb_out2, n2);
         end
         clock_edge();
      end
      rst = 1'b0; rd_we = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) model[i] = 'x;
      model[0] = 64'd0;
      test_reset();
      test_basic_write();
      test_x0();
      test_bypass();
      test_we_gating();
      test_reset_priority();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/register_file.md
# register_file

Integer register file for the RV64 core inside the SoC. It holds 32 general-purpose registers of 64 bits, with x0 hardwired to zero. It offers two combinational read ports (rs1, rs2) and one synchronous write port (rd). Decode reads operands from it and write-back writes results into it.

## Interface

One clock; reset is synchronous and active-high. The ports are named `clk` and `rst`.

Parameters:
- `XLEN`, default 64: register width in bits.
- `NREG`, default 32: number of registers. Must be a power of two.
- `BYPASS`, default 1: when 1, a same-cycle write is forwarded to the read ports (write-first). When 0, a read returns the pre-write value.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous active-high reset.
- `rs1`  in  log2(NREG)  read address, port 1.
- `rs2`  in  log2(NREG)  read address, port 2.
- `out1`  out  XLEN  read data, port 1.
- `out2`  out  XLEN  read data, port 2.
- `rd`  in  log2(NREG)  write address.
- `rd_in`  in  XLEN  write data. Narrower drivers are zero-extended by the connecting logic.
- `rd_we`  in  1  write enable.

## Operation

- Storage is registers x1..x(NREG-1), each XLEN bits. x0 has no storage.
- Read (both ports, independent and combinational):
  - Address 0: the output is 0, always.
  - BYPASS=1, `rd_we`=1, `rd`≠0 and `rd` equals the read address: the output is `rd_in`.
  - Otherwise: the output is the stored value.
- Write: at a rising `clk` with `rd_we`=1, `rd`≠0 and `rst`=0, register[`rd`] takes `rd_in`. A write to address 0 is silently discarded.
- Both read ports may address the same register, including the one being written. Both ports then return the same value.
- Reset: at a rising `clk` with `rst`=1, all registers clear to 0.
  - Reset has priority over a simultaneous write.
  - The bypass path stays active during reset. The outputs remain purely combinational.
- The block holds no state machine and has no handshake.

## Timing

- Read latency is 0 cycles; outputs are combinational from the addresses and stored state.
- Write latency is 1 edge. The value is visible from the stored array in the cycle after the edge. With BYPASS=1 it is visible in the same cycle.
- Reset is applied at the first rising edge with `rst`=1. All outputs then read 0 until the next write.
- Reset mid-operation: a write issued in the same cycle as `rst`=1 is lost.
- Before the first reset, register contents are undefined (X in simulation). x0 still reads 0.

## Structure

- Shared package `core_pkg`:
  - `XLEN`, `NREG`, `REG_AW` = $clog2(NREG).
  - Typedefs `reg_addr_t` (REG_AW bits) and `xword_t` (XLEN bits).
  - ABI register index constants (ZERO=0, RA=1, SP=2, …).
- Sub-module `regfile_read_port`, instantiated twice.
  - Inputs: address, storage array view, write address/data/enable.
  - Performs the x0 zeroing and bypass muxing.
  - `BYPASS` is passed down to it.
- The top level holds the storage array, write logic, reset, and an elaboration assertion that NREG is a power of two.

## Test plan

- Reset: hold `rst`=1 for 5 cycles, release; sweep `rs1`/`rs2` over 0..31 → every read returns 0.
- Basic write: `rd`=1, `rd_in`=1, `rd_we`=1 for one edge, then `rs1`=1, `rs2`=0 → `out1`=1, `out2`=0. Repeat with `rd`=31, `rd_in`=0xDEAD_BEEF_0123_4567 → readable on both ports.
- x0 immutability: `rd`=0, `rd_in`=0xFFFF_FFFF_FFFF_FFFF, `rd_we`=1 for one edge → `rs1`=`rs2`=0 both read 0, in the write cycle and after it.
- Bypass with BYPASS=1: in one cycle drive `rd`=5, `rd_in`=0xA5, `rd_we`=1, `rs1`=5 → `out1`=0xA5 before the edge. With BYPASS=0 → `out1` shows the old value before the edge and 0xA5 after it.
- Write-enable gating: `rd_we`=0, `rd`=3, `rd_in`=7 → x3 keeps its prior value.
- Reset priority: write x2=0x55, then assert `rst` while writing x2=0x99 → x2 reads 0 after the edge; x1 and x31 also read 0.
